// File: rtl/reg_writeback_unit_pkg.sv
// Shared types and constants for the MEM/WB writeback unit: select codes,
// load-type encodings, widths and the load-extension helpers.
package reg_writeback_unit_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_LOAD = 2'b01;
  localparam logic [1:0] WB_SEL_LINK = 2'b10;

  localparam logic [2:0] LD_W  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_HU = 3'b010;
  localparam logic [2:0] LD_B  = 3'b011;
  localparam logic [2:0] LD_BU = 3'b100;

  typedef struct packed {
    logic [REG_W-1:0]  wr_reg;
    logic [DATA_W-1:0] data;
  } aux_entry_t;

  localparam int AUX_ENTRY_W = $bits(aux_entry_t);

  // Big-endian lanes: byte 0 lives in bits 31:24, halfword 0 in bits 31:16.
  function automatic logic [DATA_W-1:0] load_extend(input logic [2:0]        load_type,
                                                    input logic [1:0]        addr_lo,
                                                    input logic [DATA_W-1:0] word);
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [DATA_W-1:0] result;
    case (addr_lo)
      2'd0:    lane_byte = word[31:24];
      2'd1:    lane_byte = word[23:16];
      2'd2:    lane_byte = word[15:8];
      default: lane_byte = word[7:0];
    endcase
    lane_half = addr_lo[1] ? word[15:0] : word[31:16];
    case (load_type)
      LD_H:    result = {{16{lane_half[15]}}, lane_half};
      LD_HU:   result = {16'h0000, lane_half};
      LD_B:    result = {{24{lane_byte[7]}}, lane_byte};
      LD_BU:   result = {24'h000000, lane_byte};
      default: result = word;
    endcase
    return result;
  endfunction

  // Unknown load types behave as lw, so they share the word alignment rule.
  function automatic logic load_misaligned(input logic [2:0] load_type,
                                           input logic [1:0] addr_lo);
    logic bad;
    case (load_type)
      LD_B, LD_BU: bad = 1'b0;
      LD_H, LD_HU: bad = addr_lo[0];
      default:     bad = (addr_lo != 2'b00);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/reg_writeback_unit_if.sv
// Bundle of MEM-stage inputs, aux result port and register-file write port.
// The slave modport is the writeback unit; the master is the surrounding pipeline.
interface reg_writeback_unit_if;
  import reg_writeback_unit_pkg::*;

  logic              mem_valid;
  logic              mem_reg_write;
  logic [REG_W-1:0]  mem_wr_reg;
  logic [1:0]        mem_wb_sel;
  logic [2:0]        mem_load_type;
  logic [DATA_W-1:0] mem_alu_result;
  logic [DATA_W-1:0] mem_read_data;
  logic [DATA_W-1:0] mem_pc_plus8;

  logic              aux_valid;
  logic              aux_ready;
  logic [REG_W-1:0]  aux_wr_reg;
  logic [DATA_W-1:0] aux_wr_data;

  logic              stall_req;
  logic              rf_reg_write;
  logic [REG_W-1:0]  rf_write_register;
  logic [DATA_W-1:0] rf_write_data;
  logic              wb_addr_err;

  modport master (
    output mem_valid, mem_reg_write, mem_wr_reg, mem_wb_sel, mem_load_type,
           mem_alu_result, mem_read_data, mem_pc_plus8,
           aux_valid, aux_wr_reg, aux_wr_data,
    input  aux_ready, stall_req, rf_reg_write, rf_write_register, rf_write_data,
           wb_addr_err
  );

  modport slave (
    input  mem_valid, mem_reg_write, mem_wr_reg, mem_wb_sel, mem_load_type,
           mem_alu_result, mem_read_data, mem_pc_plus8,
           aux_valid, aux_wr_reg, aux_wr_data,
    output aux_ready, stall_req, rf_reg_write, rf_write_register, rf_write_data,
           wb_addr_err
  );

endinterface

// File: rtl/reg_writeback_unit_wb_aux_fifo.sv
// Small synchronous FIFO buffering multi-cycle unit results until a write slot
// frees up. Head entry is visible combinationally so it can be written on pop.
module wb_aux_fifo
  import reg_writeback_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = AUX_ENTRY_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_reg[rd_ptr_reg[AW-1:0]];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (do_push && (wr_ptr_reg[AW-1:0] == AW'(gi))) begin
          mem_reg[gi] <= din;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
    end
  end

endmodule

// File: rtl/reg_writeback_unit.sv
// MEM/WB register and writeback mux; arbitrates the register-file write port between
// the pipeline and an aux FIFO. Define WB_UNALIGNED_EXC_EN to trap misaligned loads.
module reg_writeback_unit
  import reg_writeback_unit_pkg::*;
#(
  parameter int AUX_DEPTH    = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  reg_writeback_unit_if.slave  wb_bus
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT - 1);
  localparam logic [SW-1:0] STARVE_ONE = SW'(1);

  logic              wb_valid_reg;
  logic              wb_reg_write_reg;
  logic [REG_W-1:0]  wb_wr_reg_reg;
  logic [1:0]        wb_sel_reg;
  logic [2:0]        wb_load_type_reg;
  logic [DATA_W-1:0] wb_alu_result_reg;
  logic [DATA_W-1:0] wb_read_data_reg;
  logic [DATA_W-1:0] wb_pc_plus8_reg;

  logic [SW-1:0]     starve_cnt_reg;
  logic [SW-1:0]     starve_cnt_next;

  aux_entry_t        aux_in;
  aux_entry_t        aux_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              aux_push;
  logic              aux_pop;
  logic              aux_write;

  logic              addr_err;
  logic              pipe_wants;
  logic              forced;
  logic              pipe_grant;
  logic              stall_req;
  logic [DATA_W-1:0] pipe_data;

  logic              rf_we;
  logic [REG_W-1:0]  rf_reg;
  logic [DATA_W-1:0] rf_data;

  // Aux FIFO: no push while full, even in a cycle that also pops.
  assign aux_in   = '{wr_reg: wb_bus.aux_wr_reg, data: wb_bus.aux_wr_data};
  assign aux_push = wb_bus.aux_valid & ~fifo_full;

  wb_aux_fifo #(
    .DEPTH (AUX_DEPTH),
    .WIDTH (AUX_ENTRY_W)
  ) u_aux_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (aux_push),
    .pop   (aux_pop),
    .din   (aux_in),
    .dout  (aux_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef WB_UNALIGNED_EXC_EN
  assign addr_err = wb_valid_reg & wb_reg_write_reg & (wb_sel_reg == WB_SEL_LOAD) &
                    load_misaligned(wb_load_type_reg, wb_alu_result_reg[1:0]);
`else
  assign addr_err = 1'b0;
`endif

  // Everything below depends only on registered state, so stall_req has no
  // combinational path from the mem_* inputs.
  assign pipe_wants = wb_valid_reg & wb_reg_write_reg & (wb_wr_reg_reg != '0) & ~addr_err;
  assign forced     = pipe_wants & ~fifo_empty & (starve_cnt_reg == STARVE_MAX);
  assign pipe_grant = pipe_wants & ~forced;
  assign aux_pop    = ~fifo_empty & ~pipe_grant;
  assign aux_write  = aux_pop & (aux_head.wr_reg != '0);
  assign stall_req  = forced;

  always_comb begin
    case (wb_sel_reg)
      WB_SEL_LOAD: pipe_data = load_extend(wb_load_type_reg, wb_alu_result_reg[1:0],
                                           wb_read_data_reg);
      WB_SEL_LINK: pipe_data = wb_pc_plus8_reg;
      default:     pipe_data = wb_alu_result_reg;
    endcase
  end

  always_comb begin
    rf_we   = 1'b0;
    rf_reg  = '0;
    rf_data = '0;
    if (pipe_grant) begin
      rf_we   = 1'b1;
      rf_reg  = wb_wr_reg_reg;
      rf_data = pipe_data;
    end else if (aux_write) begin
      rf_we   = 1'b1;
      rf_reg  = aux_head.wr_reg;
      rf_data = aux_head.data;
    end
  end

  // Starvation counts only cycles where a waiting aux entry lost to the pipeline.
  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (fifo_empty || aux_pop) begin
      starve_cnt_next = '0;
    end else if (pipe_wants) begin
      starve_cnt_next = starve_cnt_reg + STARVE_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_reg <= '0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
    end
  end

  // On a forced slot the WB entry holds and retires on the following cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid_reg      <= 1'b0;
      wb_reg_write_reg  <= 1'b0;
      wb_wr_reg_reg     <= '0;
      wb_sel_reg        <= WB_SEL_ALU;
      wb_load_type_reg  <= LD_W;
      wb_alu_result_reg <= '0;
      wb_read_data_reg  <= '0;
      wb_pc_plus8_reg   <= '0;
    end else if (!stall_req) begin
      wb_valid_reg      <= wb_bus.mem_valid;
      wb_reg_write_reg  <= wb_bus.mem_reg_write;
      wb_wr_reg_reg     <= wb_bus.mem_wr_reg;
      wb_sel_reg        <= wb_bus.mem_wb_sel;
      wb_load_type_reg  <= wb_bus.mem_load_type;
      wb_alu_result_reg <= wb_bus.mem_alu_result;
      wb_read_data_reg  <= wb_bus.mem_read_data;
      wb_pc_plus8_reg   <= wb_bus.mem_pc_plus8;
    end
  end

  assign wb_bus.aux_ready         = ~fifo_full;
  assign wb_bus.stall_req         = stall_req;
  assign wb_bus.rf_reg_write      = rf_we;
  assign wb_bus.rf_write_register = rf_reg;
  assign wb_bus.rf_write_data     = rf_data;
  assign wb_bus.wb_addr_err       = addr_err;

endmodule
